// File: rtl/frame_convencoder_ctrl_if.sv
// Bit-serial handshake bundle between scrambler, framing encoder and interleaver.
// master = environment side (drives input bits and downstream ready), slave = encoder side.
interface frame_convencoder_ctrl_if;
   logic in_valid;
   logic in_data;
   logic in_ready;
   logic out_valid;
   logic out_data;
   logic out_coded;
   logic out_last;
   logic out_ready;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_coded, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_coded, out_last
   );
endinterface

// File: rtl/frame_convencoder_ctrl.sv
// TX framing encoder: hunts the preamble, passes SIGNAL through, then K=7 convolutional
// encodes DATA plus a zero tail with 1/2, 2/3 or 3/4 puncturing.
//
// state  | meaning
// HUNT   | forward bits uncoded, count consecutive ones up to PRE_LEN
// SIGNAL | forward SIG_LEN bits uncoded, latch rate on exit
// DATA   | encode DATA_LEN accepted bits
// TAIL   | inject 6 internal zeros, wait for the last coded bit to leave
// DONE   | idle until en drops
module frame_convencoder_ctrl #(
   parameter int PRE_LEN  = 12,
   parameter int SIG_LEN  = 24,
   parameter int DATA_LEN = 96,
   parameter int CNT_W    = 10
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] rate,
   frame_convencoder_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      S_HUNT,
      S_SIGNAL,
      S_DATA,
      S_TAIL,
      S_DONE
   } state_t;

   localparam logic [1:0] R_12 = 2'b00;
   localparam logic [1:0] R_23 = 2'b01;
   localparam logic [1:0] R_34 = 2'b10;

   localparam logic [6:0] G0 = 7'o133;
   localparam logic [6:0] G1 = 7'o171;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] PRE_END   = CNT_W'(PRE_LEN - 1);
   localparam logic [CNT_W-1:0] SIG_END   = CNT_W'(SIG_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_LEN - 1);
   localparam logic [CNT_W-1:0] TAIL_LEN  = CNT_W'(6);
   localparam logic [CNT_W-1:0] TAIL_END  = CNT_W'(5);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [5:0]       sr;
   logic [1:0]       phase;
   logic [1:0]       rate_q;
   logic             pend;
   logic             pend_bit;
   logic             pend_last;
   logic             tx_valid;
   logic             tx_data;
   logic             tx_coded;
   logic             tx_last;

   logic       slot_free;
   logic       in_open;
   logic       accept;
   logic       tail_step;
   logic       enc_step;
   logic       out_fire;
   logic       u;
   logic [6:0] vec;
   logic       code_a;
   logic       code_b;
   logic       keep_a;
   logic       keep_b;
   logic       last_in;
   logic [1:0] phase_nxt;

   // A new bit may enter only when no B is waiting and the output register will be free.
   assign slot_free = !pend && (!tx_valid || bus.out_ready);
   assign in_open   = (state == S_HUNT) || (state == S_SIGNAL) || (state == S_DATA);
   assign bus.in_ready = rst_n && en && in_open && slot_free;
   assign accept    = bus.in_ready && bus.in_valid;
   assign tail_step = en && (state == S_TAIL) && (cnt != TAIL_LEN) && slot_free;
   assign enc_step  = (accept && (state == S_DATA)) || tail_step;
   assign out_fire  = tx_valid && bus.out_ready;

   assign u      = (state == S_TAIL) ? 1'b0 : bus.in_data;
   assign vec    = {u, sr};
   assign code_a = ^(G0 & vec);
   assign code_b = ^(G1 & vec);

   assign keep_a  = !((rate_q == R_34) && (phase == 2'd2));
   assign keep_b  = !((phase == 2'd1) && ((rate_q == R_23) || (rate_q == R_34)));
   assign last_in = (state == S_TAIL) && (cnt == TAIL_END);

   always_comb begin
      phase_nxt = 2'd0;
      case (rate_q)
         R_23:    phase_nxt = (phase == 2'd1) ? 2'd0 : 2'd1;
         R_34:    phase_nxt = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
         default: phase_nxt = 2'd0;
      endcase
   end

   assign bus.out_valid = tx_valid;
   assign bus.out_data  = tx_data;
   assign bus.out_coded = tx_coded;
   assign bus.out_last  = tx_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_HUNT;
         cnt       <= '0;
         sr        <= '0;
         phase     <= '0;
         rate_q    <= R_12;
         pend      <= 1'b0;
         pend_bit  <= 1'b0;
         pend_last <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 1'b0;
         tx_coded  <= 1'b0;
         tx_last   <= 1'b0;
      end else if (!en) begin
         state     <= S_HUNT;
         cnt       <= '0;
         sr        <= '0;
         phase     <= '0;
         pend      <= 1'b0;
         pend_bit  <= 1'b0;
         pend_last <= 1'b0;
         tx_valid  <= 1'b0;
         tx_data   <= 1'b0;
         tx_coded  <= 1'b0;
         tx_last   <= 1'b0;
      end else begin
         if (out_fire) begin
            if (pend) begin
               tx_data   <= pend_bit;
               tx_last   <= pend_last;
               pend      <= 1'b0;
               pend_last <= 1'b0;
            end else begin
               tx_valid <= 1'b0;
               tx_last  <= 1'b0;
            end
         end

         case (state)
            S_HUNT: begin
               if (accept) begin
                  tx_valid <= 1'b1;
                  tx_data  <= bus.in_data;
                  tx_coded <= 1'b0;
                  tx_last  <= 1'b0;
                  if (!bus.in_data) begin
                     cnt <= '0;
                  end else if (cnt == PRE_END) begin
                     state <= S_SIGNAL;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end

            S_SIGNAL: begin
               if (accept) begin
                  tx_valid <= 1'b1;
                  tx_data  <= bus.in_data;
                  tx_coded <= 1'b0;
                  tx_last  <= 1'b0;
                  if (cnt == SIG_END) begin
                     state  <= S_DATA;
                     cnt    <= '0;
                     phase  <= '0;
                     rate_q <= (rate == 2'b11) ? R_12 : rate;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
            end

            S_DATA, S_TAIL: begin
               if (enc_step) begin
                  sr       <= {u, sr[5:1]};
                  phase    <= phase_nxt;
                  cnt      <= cnt + CNT_ONE;
                  tx_valid <= 1'b1;
                  tx_coded <= 1'b1;
                  if (keep_a) begin
                     tx_data <= code_a;
                     if (keep_b) begin
                        pend      <= 1'b1;
                        pend_bit  <= code_b;
                        pend_last <= last_in;
                        tx_last   <= 1'b0;
                     end else begin
                        tx_last <= last_in;
                     end
                  end else begin
                     // 3/4 phase 2: A is punctured, so B goes straight out
                     tx_data <= code_b;
                     tx_last <= last_in;
                  end
                  if ((state == S_DATA) && (cnt == DATA_END)) begin
                     state <= S_TAIL;
                     cnt   <= '0;
                  end
               end
               if ((state == S_TAIL) && out_fire && tx_last) begin
                  state <= S_DONE;
               end
            end

            S_DONE: begin
               tx_valid <= 1'b0;
            end

            default: begin
               state <= S_HUNT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_frame_convencoder_ctrl.sv
// Scoreboard bench for frame_convencoder_ctrl: a frame-level reference model queues the
// expected output bits as stimulus is accepted; a monitor pops and compares on every output transfer.
module tb_frame_convencoder_ctrl;
   localparam int PRE_LEN  = 12;
   localparam int SIG_LEN  = 24;
   localparam int DATA_LEN = 96;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [1:0] rate = 2'b00;

   frame_convencoder_ctrl_if bus ();

   frame_convencoder_ctrl #(
      .PRE_LEN (PRE_LEN),
      .SIG_LEN (SIG_LEN),
      .DATA_LEN(DATA_LEN),
      .CNT_W   (10)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (en),
      .rate (rate),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [2:0] exp_q[$];
   logic cap[0:255];
   int cap_n = 0;
   bit rand_ready = 1'b0;
   bit stall = 1'b0;

   // reference model state: 0 hunt, 1 signal, 2 data, 3 frame fully issued
   int m_state = 0;
   int m_cnt = 0;
   int m_rate = 0;
   bit m_u[$];

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic void model_reset();
      m_state = 0;
      m_cnt = 0;
      m_u.delete();
   endfunction

   function automatic bit ubit(input int n);
      if (n < 0) return 1'b0;
      return m_u[n];
   endfunction

   // Convolution written directly on the input history: A taps delays 0,2,3,5,6; B taps 0,1,2,3,6.
   function automatic void model_code(input int n);
      bit a, b, ka, kb, last;
      int per, k;
      a = ubit(n) ^ ubit(n-2) ^ ubit(n-3) ^ ubit(n-5) ^ ubit(n-6);
      b = ubit(n) ^ ubit(n-1) ^ ubit(n-2) ^ ubit(n-3) ^ ubit(n-6);
      per = (m_rate == 1) ? 2 : (m_rate == 2) ? 3 : 1;
      k = n % per;
      ka = !(m_rate == 2 && k == 2);
      kb = !(k == 1 && (m_rate == 1 || m_rate == 2));
      last = (n == DATA_LEN + 5);
      if (ka) exp_q.push_back({a, 1'b1, last && !kb});
      if (kb) exp_q.push_back({b, 1'b1, last});
   endfunction

   function automatic void model_bit(input bit b);
      case (m_state)
         0: begin
            exp_q.push_back({b, 1'b0, 1'b0});
            if (b) begin
               m_cnt++;
               if (m_cnt == PRE_LEN) begin m_state = 1; m_cnt = 0; end
            end else begin
               m_cnt = 0;
            end
         end
         1: begin
            exp_q.push_back({b, 1'b0, 1'b0});
            m_cnt++;
            if (m_cnt == SIG_LEN) begin
               m_state = 2;
               m_rate = (rate == 2'b11) ? 0 : int'(rate);
            end
         end
         2: begin
            m_u.push_back(b);
            model_code(m_u.size() - 1);
            if (m_u.size() == DATA_LEN) begin
               for (int i = 0; i < 6; i++) begin
                  m_u.push_back(1'b0);
                  model_code(m_u.size() - 1);
               end
               m_state = 3;
            end
         end
         default: ;
      endcase
   endfunction

   function automatic int exp_coded(input int r);
      int n2;
      n2 = 2 * (DATA_LEN + 6);
      if (r == 1) return n2 * 3 / 4;
      if (r == 2) return n2 * 2 / 3;
      return n2;
   endfunction

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      end
   end

   always @(negedge clk) begin
      logic [2:0] e;
      if (rst_n && bus.out_valid && bus.out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out actual=%b%b%b required=none", bus.out_data, bus.out_coded, bus.out_last);
         end else begin
            e = exp_q.pop_front();
            if ({bus.out_data, bus.out_coded, bus.out_last} !== e) begin
               failures++;
               $display("FAIL scoreboard actual(data,coded,last)=%b%b%b required=%b", bus.out_data, bus.out_coded, bus.out_last, e);
            end
         end
         if (bus.out_coded && cap_n < 256) begin
            cap[cap_n] = bus.out_data;
            cap_n++;
         end
      end
   end

   task automatic send_bit(input bit b);
      int t;
      bit acc;
      int gap;
      t = 0;
      acc = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = b;
      while (!acc && t < 1000) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         t++;
      end
      bus.in_valid = 1'b0;
      bus.in_data = 1'($urandom_range(0, 1));
      if (acc) model_bit(b);
      else chk("send_timeout", 0, 1);
      gap = rand_ready ? $urandom_range(0, 1) : 0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   // kind: 0 impulse data, 1 broken preamble then impulse, 2 noise prefix + random data
   // abort: 0 none, 1 reset pulse at data bit 50, 2 en drop while in TAIL
   task automatic run_frame(input int r, input int kind, input bit rr, input int abort);
      bit bits[$];
      int n, t, len;
      logic [11:0] head;
      rate = 2'(r);
      rand_ready = rr;
      cap_n = 0;
      if (kind == 1) begin
         repeat (11) bits.push_back(1'b1);
         bits.push_back(1'b0);
      end else if (kind == 2) begin
         n = $urandom_range(3, 15);
         repeat (n) bits.push_back(1'($urandom_range(0, 1)));
         bits.push_back(1'b0);
      end
      repeat (PRE_LEN) bits.push_back(1'b1);
      repeat (SIG_LEN) bits.push_back(1'($urandom_range(0, 1)));
      for (int i = 0; i < DATA_LEN; i++)
         bits.push_back(kind == 2 ? 1'($urandom_range(0, 1)) : (i == 0));

      n = 0;
      while (m_state != 3 && n < 400) begin
         send_bit(n < bits.size() ? bits[n] : 1'($urandom_range(0, 1)));
         n++;
         if (abort == 1 && m_state == 2 && m_u.size() == 50) begin
            rst_n = 1'b0;
            #1;
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_out_data", int'(bus.out_data), 0);
            chk("rst_out_coded", int'(bus.out_coded), 0);
            chk("rst_out_last", int'(bus.out_last), 0);
            chk("rst_in_ready", int'(bus.in_ready), 0);
            exp_q.delete();
            model_reset();
            @(posedge clk);
            #3;
            rst_n = 1'b1;
            rand_ready = 1'b0;
            return;
         end
      end
      chk("frame_issued", m_state, 3);

      if (abort == 2) begin
         stall = 1'b1;
         @(posedge clk);
         #2;
         en = 1'b0;
         exp_q.delete();
         @(posedge clk);
         #2;
         chk("en_drop_out_valid", int'(bus.out_valid), 0);
         chk("en_drop_in_ready", int'(bus.in_ready), 0);
         en = 1'b1;
         stall = 1'b0;
         model_reset();
         rand_ready = 1'b0;
         return;
      end

      t = 0;
      while (exp_q.size() != 0 && t < 3000) begin
         @(posedge clk);
         t++;
      end
      chk("drain_left", exp_q.size(), 0);
      @(negedge clk);
      chk("done_out_valid", int'(bus.out_valid), 0);
      chk("done_in_ready", int'(bus.in_ready), 0);
      chk("coded_count", cap_n, exp_coded(r == 3 ? 0 : r));

      if (kind != 2) begin
         len = (r == 2) ? 6 : (r == 1) ? 9 : 12;
         head = '0;
         for (int i = 0; i < len; i++) head = {head[10:0], cap[i]};
         if (r == 2)      chk("impulse_head_34", int'(head), int'(12'b000000_110111));
         else if (r == 1) chk("impulse_head_23", int'(head), int'(12'b000_110111001));
         else             chk("impulse_head_12", int'(head), int'(12'b110111110010));
      end

      rand_ready = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b1;
      model_reset();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", int'(bus.out_valid), 0);
      chk("reset_out_data", int'(bus.out_data), 0);
      chk("reset_out_coded", int'(bus.out_coded), 0);
      chk("reset_out_last", int'(bus.out_last), 0);
      chk("reset_in_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b1;
      model_reset();

      run_frame(0, 0, 1'b0, 0);
      run_frame(2, 0, 1'b0, 0);
      run_frame(1, 0, 1'b0, 0);
      run_frame(3, 0, 1'b0, 0);
      run_frame(0, 1, 1'b0, 0);
      run_frame(0, 0, 1'b1, 0);
      run_frame(2, 2, 1'b1, 0);
      run_frame(0, 0, 1'b0, 1);
      run_frame(0, 0, 1'b0, 0);
      run_frame(1, 0, 1'b0, 2);
      run_frame(0, 0, 1'b0, 0);
      for (int f = 0; f < 4; f++)
         run_frame($urandom_range(0, 3), 2, 1'($urandom_range(0, 1)), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "timeout");
   end
endmodule
